// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched, maskable, fixed-priority requests multiplexed
// onto one CPU INTERRUPT level, acknowledged by writing the served index back.
module intr_ctrl #(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] ID_MASK  = 8'h20,
    parameter logic [7:0] ID_PEND  = 8'h21,
    parameter logic [7:0] ID_CAUSE = 8'h22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic             INTERRUPT,
    output logic [7:0]       RD_DATA,
    output logic             RD_HIT
);
    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] rise, elig, ack_clr;
    logic [2:0]       cause_q, cause_d, first_idx;
    logic             int_q, int_d;
    logic             ack;
    logic             unused_ok;

    assign unused_ok = &{1'b0, OUT_PORT};

    always_comb begin
        rise = IRQ & ~irq_q;
        elig = pend_q & mask_q;
        ack  = IO_STRB && (PORT_ID == ID_CAUSE) && (state_q == ASSERT) &&
               (OUT_PORT[2:0] == cause_q);

        // Scan downward so the lowest eligible index wins.
        first_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (elig[i]) first_idx = 3'(i);

        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++)
            ack_clr[i] = ack && (cause_q == 3'(i));

        // A new edge on the acknowledged bit keeps it pending.
        pend_d = (pend_q & ~ack_clr) | rise;
        mask_d = (IO_STRB && (PORT_ID == ID_MASK)) ? OUT_PORT[N_SRC-1:0] : mask_q;

        state_d = state_q;
        cause_d = cause_q;
        int_d   = int_q;
        case (state_q)
            IDLE: if (|elig) begin
                cause_d = first_idx;
                int_d   = 1'b1;
                state_d = ASSERT;
            end
            ASSERT: if (ack) begin
                int_d   = 1'b0;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            irq_q   <= '0;
            cause_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            irq_q   <= IRQ;
            cause_q <= cause_d;
            int_q   <= int_d;
        end
    end

    always_comb begin
        RD_DATA = 8'h00;
        if (PORT_ID == ID_MASK)       RD_DATA = 8'(mask_q);
        else if (PORT_ID == ID_PEND)  RD_DATA = 8'(pend_q);
        else if (PORT_ID == ID_CAUSE) RD_DATA = {5'b0, cause_q};
    end

    assign RD_HIT    = (PORT_ID == ID_MASK) || (PORT_ID == ID_PEND) || (PORT_ID == ID_CAUSE);
    assign INTERRUPT = int_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed vector table, hand sequences for corner cases,
// then random traffic checked against a cycle-level behavioural model.
module tb_intr_ctrl;
    localparam int N = 4;

    logic         CLK = 1'b0, RESET = 1'b0;
    logic [N-1:0] IRQ = '0;
    logic [7:0]   PORT_ID = 8'h00, OUT_PORT = 8'h00;
    logic         IO_STRB = 1'b0;
    logic         INTERRUPT, RD_HIT;
    logic [7:0]   RD_DATA;

    intr_ctrl #(.N_SRC(N), .ID_MASK(8'h20), .ID_PEND(8'h21), .ID_CAUSE(8'h22)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .IO_STRB(IO_STRB), .INTERRUPT(INTERRUPT), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;

    // Reference model: which source is being served (-1 = none), plus a gap flag.
    bit m_pend[N], m_mask[N], m_prev[N];
    int m_serving, m_cause;
    bit m_gap;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
        end
        m_serving = -1; m_cause = 0; m_gap = 0;
    endfunction

    function automatic void model_update();
        bit ack;
        int pick;
        ack = IO_STRB && PORT_ID == 8'h22 && m_serving >= 0 && int'(OUT_PORT[2:0]) == m_cause;
        pick = -1;
        for (int i = 0; i < N; i++)
            if (pick < 0 && m_pend[i] && m_mask[i]) pick = i;
        if (m_gap) m_gap = 0;
        else if (m_serving < 0) begin
            if (pick >= 0) begin m_serving = pick; m_cause = pick; end
        end else if (ack) begin
            m_serving = -1; m_gap = 1;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = (IRQ[i] && !m_prev[i]) || (m_pend[i] && !(ack && i == m_cause));
            m_prev[i] = IRQ[i];
        end
        if (IO_STRB && PORT_ID == 8'h20)
            for (int i = 0; i < N; i++) m_mask[i] = OUT_PORT[i];
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] pid);
        logic [7:0] v = 8'h00;
        if (pid == 8'h20) for (int i = 0; i < N; i++) v[i] = m_mask[i];
        else if (pid == 8'h21) for (int i = 0; i < N; i++) v[i] = m_pend[i];
        else if (pid == 8'h22) v = 8'(m_cause);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] irq, input logic [7:0] pid, input logic [7:0] out,
                        input logic strb);
        IRQ = irq; PORT_ID = pid; OUT_PORT = out; IO_STRB = strb;
        model_update();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic [7:0]   pid;
        logic [7:0]   out;
        logic         strb;
        logic         ei;
        logic [7:0]   erd;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'h0, 8'h20, 8'h0F, 1'b1, 1'b0, 8'h0F};
        tbl[1]  = '{4'h4, 8'h21, 8'h00, 1'b0, 1'b0, 8'h04};
        tbl[2]  = '{4'h0, 8'h22, 8'h00, 1'b0, 1'b1, 8'h02};
        tbl[3]  = '{4'h0, 8'h21, 8'h00, 1'b0, 1'b1, 8'h04};
        tbl[4]  = '{4'h0, 8'h22, 8'h03, 1'b1, 1'b1, 8'h02};
        tbl[5]  = '{4'h0, 8'h22, 8'h02, 1'b1, 1'b0, 8'h02};
        tbl[6]  = '{4'h0, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{4'hA, 8'h21, 8'h00, 1'b0, 1'b0, 8'h0A};
        tbl[8]  = '{4'hA, 8'h22, 8'h00, 1'b0, 1'b1, 8'h01};
        tbl[9]  = '{4'h0, 8'h22, 8'h01, 1'b1, 1'b0, 8'h01};
        tbl[10] = '{4'h0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h01};
        tbl[11] = '{4'h0, 8'h22, 8'h00, 1'b0, 1'b1, 8'h03};
        tbl[12] = '{4'h0, 8'h22, 8'h03, 1'b1, 1'b0, 8'h03};

        model_reset();
        #1 RESET = 1'b1;
        #7;
        chk("reset int", {7'b0, INTERRUPT}, 8'h00);
        PORT_ID = 8'h20; #1 chk("reset mask", RD_DATA, 8'h00);
        PORT_ID = 8'h21; #1 chk("reset pend", RD_DATA, 8'h00);
        PORT_ID = 8'h22; #1 chk("reset cause", RD_DATA, 8'h00);
        #1 RESET = 1'b0;
        @(posedge CLK); #1;

        // Single source, wrong ack, priority and gap.
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].irq, tbl[k].pid, tbl[k].out, tbl[k].strb);
            chk($sformatf("vec%0d int", k), {7'b0, INTERRUPT}, {7'b0, tbl[k].ei});
            chk($sformatf("vec%0d rd", k), RD_DATA, tbl[k].erd);
        end

        // Masked source stays pending; unmasking serves it two edges after the write.
        step(4'h0, 8'h20, 8'h00, 1'b1);
        step(4'h1, 8'h21, 8'h00, 1'b0);
        chk("masked pend", RD_DATA, 8'h01);
        for (int k = 0; k < 3; k++) begin
            step(4'h0, 8'h21, 8'h00, 1'b0);
            chk("masked int", {7'b0, INTERRUPT}, 8'h00);
        end
        step(4'h0, 8'h20, 8'h01, 1'b1);
        chk("unmask edge int", {7'b0, INTERRUPT}, 8'h00);
        step(4'h0, 8'h22, 8'h00, 1'b0);
        chk("unmask next int", {7'b0, INTERRUPT}, 8'h01);
        chk("unmask cause", RD_DATA, 8'h00);

        // Wrong acknowledge, then ack colliding with a new edge on the same source.
        step(4'h0, 8'h22, 8'h01, 1'b1);
        chk("wrong ack int", {7'b0, INTERRUPT}, 8'h01);
        step(4'h1, 8'h22, 8'h00, 1'b1);
        chk("collide int", {7'b0, INTERRUPT}, 8'h00);
        step(4'h1, 8'h21, 8'h00, 1'b0);
        chk("collide gap int", {7'b0, INTERRUPT}, 8'h00);
        chk("collide pend", RD_DATA, 8'h01);
        step(4'h0, 8'h21, 8'h00, 1'b0);
        chk("collide reassert", {7'b0, INTERRUPT}, 8'h01);
        step(4'h0, 8'h22, 8'h00, 1'b1);
        step(4'h0, 8'h21, 8'h00, 1'b0);
        chk("collide cleared", RD_DATA, 8'h00);

        // Held level sets pending only once.
        step(4'h0, 8'h20, 8'h02, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k == 2) step(4'h2, 8'h22, 8'h01, 1'b1);
            else        step(4'h2, 8'h21, 8'h00, 1'b0);
            if (k == 0) chk("held pend", RD_DATA, 8'h02);
            if (k == 1) chk("held int", {7'b0, INTERRUPT}, 8'h01);
            if (k >= 3) begin
                chk($sformatf("held%0d int", k), {7'b0, INTERRUPT}, 8'h00);
                chk($sformatf("held%0d pend", k), RD_DATA, 8'h00);
            end
        end
        step(4'h0, 8'h21, 8'h00, 1'b0);

        // Reset mid-service acts without a clock edge.
        step(4'h2, 8'h21, 8'h00, 1'b0);
        step(4'h0, 8'h21, 8'h00, 1'b0);
        chk("pre-reset int", {7'b0, INTERRUPT}, 8'h01);
        #2 RESET = 1'b1;
        #1 chk("async int", {7'b0, INTERRUPT}, 8'h00);
        PORT_ID = 8'h20; #1 chk("async mask", RD_DATA, 8'h00);
        PORT_ID = 8'h21; #1 chk("async pend", RD_DATA, 8'h00);
        chk("hit pend", {7'b0, RD_HIT}, 8'h01);
        PORT_ID = 8'h23; #0.5 chk("hit other", {7'b0, RD_HIT}, 8'h00);
        model_reset();
        #0.5 RESET = 1'b0;
        @(posedge CLK); #1;

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] pid, out;
            int sel;
            sel = $urandom_range(0, 3);
            pid = (sel == 0) ? 8'h20 : (sel == 1) ? 8'h21 : (sel == 2) ? 8'h22 : 8'($urandom);
            out = (pid == 8'h22 && $urandom_range(0, 1) == 1) ? 8'(m_cause) : 8'($urandom);
            step(N'($urandom), pid, out, $urandom_range(0, 2) == 0);
            chk($sformatf("rnd%0d int", k), {7'b0, INTERRUPT}, {7'b0, m_serving >= 0});
            chk($sformatf("rnd%0d rd", k), RD_DATA, model_rd(PORT_ID));
            chk($sformatf("rnd%0d hit", k), {7'b0, RD_HIT},
                {7'b0, PORT_ID == 8'h20 || PORT_ID == 8'h21 || PORT_ID == 8'h22});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
